fifo_wr_arb: RTL and testbench
==============================

FIFO_WR_ARB -- requirements
Module: fifo_wr_arb

Interface
REQ-001 Parameter WORDSIZE, default 8: width of one data word, in bits.
REQ-002 Parameter NREQ, default 4: number of write requesters, range 2..16.
REQ-003 Parameter BURST_LEN, default 4: maximum consecutive words per grant when bursting is enabled, range 1..255.
REQ-004 Clocking: one clock; reset is synchronous and active-low. Port wclk is the clock and wrst_n is the reset.
REQ-005 wclk  input  1  write-domain clock; all state updates on its rising edge.
REQ-006 wrst_n  input  1  synchronous active-low reset.
REQ-007 req  input  NREQ  per-requester write request; bit i belongs to requester i.
REQ-008 req_data  input  NREQ*WORDSIZE  packed request words; requester i occupies bits [i*WORDSIZE +: WORDSIZE].
REQ-009 gnt  output  NREQ  one-hot accept strobe; bit i high means requester i's word is written this cycle.
REQ-010 gnt_id  output  clog2(NREQ)  index of the current or last granted requester.
REQ-011 wfull  input  1  FIFO full flag from the write-pointer logic.
REQ-012 wclken  output  1  FIFO memory write enable.
REQ-013 wdata  output  WORDSIZE  word driven to the FIFO memory write port.

Function
REQ-014 The block SHALL accept at most one word per cycle; gnt SHALL be zero or one-hot.
REQ-015 gnt[i] SHALL assert combinationally in the same cycle that req[i] is high, wfull is low and i wins arbitration; accept latency is 0 cycles.
REQ-016 wclken SHALL equal the OR of all gnt bits, and wdata SHALL equal req_data of the granted requester in the same cycle.
REQ-017 When no requester is granted, wdata SHALL be all-zero.
REQ-018 While wfull is high, gnt SHALL be all-zero and wclken SHALL be low; no arbitration or burst state SHALL change.
REQ-019 Requester handshake:
- each gnt pulse consumes exactly one word;
- a requester SHALL hold req and req_data stable until gnt;
- req may deassert without a grant, and that word is then withdrawn.
REQ-020 Arbitration SHALL be round-robin. Priority starts at (last granted index + 1) mod NREQ and increases with index, wrapping from NREQ-1 to 0.
REQ-021 The arbitration pointer SHALL update only on a cycle with an accept.
REQ-022 FSM state IDLE: the block arbitrates every cycle.
REQ-023 FSM state BURST exists only when bursting is compiled in. In BURST the grant stays with gnt_id.
REQ-024 The FSM SHALL return from BURST to IDLE when any of these holds, and that requester then becomes lowest priority:
- req[gnt_id] is low;
- burst_cnt reaches BURST_LEN.
REQ-025 burst_cnt SHALL be 8 bits wide, increment on each accept in BURST, and reset to 1 on entry to BURST.
REQ-026 gnt_id SHALL hold its value when there is no accept.

Reset
REQ-027 On a wclk edge with wrst_n low, the block SHALL load:
- state IDLE;
- arbitration pointer such that requester 0 has highest priority;
- burst_cnt 0;
- gnt_id 0.
REQ-028 While wrst_n is low, gnt SHALL be all-zero and wclken SHALL be low, regardless of req and wfull.
REQ-029 A reset asserted mid-burst SHALL abandon the burst, and the next cycle after release SHALL arbitrate from requester 0.

Configuration
REQ-030 Macro FIFO_WR_ARB_BURST_EN:
- when defined, the BURST state and burst_cnt SHALL exist and a grant SHALL be held for up to BURST_LEN consecutive accepts;
- when undefined, the FSM SHALL stay in IDLE and the pointer SHALL rotate after every accepted word.

Verification
REQ-031 Scenario: NREQ=4, burst off, req=4'b1111 continuously, wfull=0 -> gnt sequence 0001,0010,0100,1000,0001; wclken=1 every cycle.
REQ-032 Scenario: req[2] held with req_data[2]=8'hA5, wfull high for 3 cycles then low -> gnt=0 and wclken=0 for 3 cycles; then gnt=0100 with wdata=8'hA5 in the first cycle after wfull falls.
REQ-033 Scenario: burst on, BURST_LEN=4, req=4'b0011 continuously -> gnt 0001 for 4 cycles, then 0010 for 4 cycles, then 0001.
REQ-034 Scenario: burst on, req[0] drops after 2 accepts while req[3] is high -> next gnt=1000, state IDLE, then BURST on requester 3.
REQ-035 Scenario: wrst_n pulsed low for 1 cycle mid-burst on requester 2, with req=4'b0101 -> gnt=0 during reset; first grant after release is 0001.
REQ-036 Scenario: req=0 for 10 cycles -> gnt=0, wclken=0, wdata=0, and gnt_id unchanged throughout.

Source files
------------

// File: rtl/fifo_wr_arb.sv
`default_nettype none
// ============================================================================
// Module      : fifo_wr_arb
// Description : Round-robin write arbiter in front of a FIFO write port.
//               Up to NREQ requesters present one word each; at most one word
//               is accepted per cycle, combinationally (zero-latency gnt).
//               With FIFO_WR_ARB_BURST_EN defined, a winner keeps the grant
//               for up to BURST_LEN consecutive accepts.
// Ports       : wclk      - write-domain clock (rising edge)
//               wrst_n    - synchronous active-low reset
//               req       - per-requester write request
//               req_data  - packed words, requester i at [i*WORDSIZE +: WORDSIZE]
//               gnt       - one-hot accept strobe (zero when idle/full/reset)
//               gnt_id    - index of current or last granted requester
//               wfull     - FIFO full flag
//               wclken    - FIFO memory write enable
//               wdata     - word to FIFO memory (zero when nothing granted)
// Macro       : FIFO_WR_ARB_BURST_EN (optional burst mode)
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_wr_arb #(
    parameter int WORDSIZE  = 8,
    parameter int NREQ      = 4,
    parameter int BURST_LEN = 4
) (
    input  logic                       wclk,
    input  logic                       wrst_n,
    input  logic [NREQ-1:0]            req,
    input  logic [NREQ*WORDSIZE-1:0]   req_data,
    output logic [NREQ-1:0]            gnt,
    output logic [$clog2(NREQ)-1:0]    gnt_id,
    input  logic                       wfull,
    output logic                       wclken,
    output logic [WORDSIZE-1:0]        wdata
);

    localparam int           c_IDW  = $clog2(NREQ);
    localparam logic [7:0]   c_BLEN = 8'(BURST_LEN);

    // Index of the last accepted requester; priority starts one above it.
    logic [c_IDW-1:0] r_ptr;

    logic             w_win_vld;
    logic [c_IDW-1:0] w_win_id;
    logic             w_sel_vld;
    logic [c_IDW-1:0] w_sel_id;
    logic             w_acc;

    // Round-robin search starting at r_ptr+1, wrapping at NREQ.
    always_comb begin
        int v_idx;
        w_win_vld = 1'b0;
        w_win_id  = '0;
        v_idx     = 0;
        for (int k = 0; k < NREQ; k++) begin
            v_idx = (int'(r_ptr) + 1 + k) % NREQ;
            if (!w_win_vld && req[v_idx]) begin
                w_win_vld = 1'b1;
                w_win_id  = v_idx[c_IDW-1:0];
            end
        end
    end

`ifdef FIFO_WR_ARB_BURST_EN
    localparam logic [0:0] c_IDLE  = 1'b0;
    localparam logic [0:0] c_BURST = 1'b1;

    logic [0:0] r_state;
    logic [7:0] r_burst_cnt;
    logic       w_hold;

    // Burst continues only while the owner still requests and has budget left;
    // otherwise this same cycle arbitrates normally, with the owner already
    // sitting at lowest priority because r_ptr equals gnt_id during a burst.
    assign w_hold    = (r_state == c_BURST) && req[gnt_id] && (r_burst_cnt < c_BLEN);
    assign w_sel_vld = w_hold ? 1'b1   : w_win_vld;
    assign w_sel_id  = w_hold ? gnt_id : w_win_id;
    assign w_acc     = wrst_n && !wfull && w_sel_vld;

    always_ff @(posedge wclk) begin
        if (!wrst_n) begin
            r_state     <= c_IDLE;
            r_ptr       <= c_IDW'(NREQ - 1);
            r_burst_cnt <= 8'd0;
            gnt_id      <= '0;
        end else if (w_acc) begin
            r_ptr  <= w_sel_id;
            gnt_id <= w_sel_id;
            if (w_hold) begin
                r_burst_cnt <= r_burst_cnt + 8'd1;
            end else begin
                // The accepted word is the first of a new burst.
                r_state     <= c_BURST;
                r_burst_cnt <= 8'd1;
            end
        end else if (!wfull && (r_state == c_BURST) && !w_hold) begin
            r_state <= c_IDLE;
        end
    end
`else
    logic w_unused_blen;
    assign w_unused_blen = ^c_BLEN;

    assign w_sel_vld = w_win_vld;
    assign w_sel_id  = w_win_id;
    assign w_acc     = wrst_n && !wfull && w_sel_vld;

    always_ff @(posedge wclk) begin
        if (!wrst_n) begin
            r_ptr  <= c_IDW'(NREQ - 1);
            gnt_id <= '0;
        end else if (w_acc) begin
            r_ptr  <= w_sel_id;
            gnt_id <= w_sel_id;
        end
    end
`endif

    always_comb begin
        gnt = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_acc && (w_sel_id == i[c_IDW-1:0])) begin
                gnt[i] = 1'b1;
            end
        end
    end

    always_comb begin
        wdata = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                wdata = req_data[i*WORDSIZE +: WORDSIZE];
            end
        end
    end

    assign wclken = |gnt;

endmodule
`default_nettype wire

// File: tb/tb_fifo_wr_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_wr_arb
// Description : Scoreboard bench for fifo_wr_arb (NREQ=4, WORDSIZE=8,
//               BURST_LEN=4). Expected vectors follow the build: burst
//               sequences when FIFO_WR_ARB_BURST_EN is defined, plain
//               round-robin otherwise.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_wr_arb;

    logic        wclk;
    logic        wrst_n;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  gnt;
    logic [1:0]  gnt_id;
    logic        wfull;
    logic        wclken;
    logic [7:0]  wdata;

    fifo_wr_arb #(.WORDSIZE(8), .NREQ(4), .BURST_LEN(4)) dut (
        .wclk     (wclk),
        .wrst_n   (wrst_n),
        .req      (req),
        .req_data (req_data),
        .gnt      (gnt),
        .gnt_id   (gnt_id),
        .wfull    (wfull),
        .wclken   (wclken),
        .wdata    (wdata)
    );

    initial wclk = 1'b0;
    always #5 wclk = ~wclk;

    typedef struct packed {
        logic [3:0] g;
        logic [7:0] d;
        logic [1:0] id;
    } exp_t;

    exp_t q_exp[$];
    int   n_tests;
    int   n_fail;

    // Requester words: r0=10, r1=21, r2=A5, r3=3C.
    function automatic logic [7:0] word_of(input logic [3:0] g);
        case (g)
            4'b0001: return 8'h10;
            4'b0010: return 8'h21;
            4'b0100: return 8'hA5;
            4'b1000: return 8'h3C;
            default: return 8'h00;
        endcase
    endfunction

    task automatic step(input logic rn, input logic [3:0] rq, input logic wf,
                        input logic [3:0] eg, input logic [1:0] eid);
        exp_t e;
        wrst_n = rn;
        req    = rq;
        wfull  = wf;
        e.g  = eg;
        e.d  = word_of(eg);
        e.id = eid;
        q_exp.push_back(e);
        @(posedge wclk);
        #1;
    endtask

    // Monitor: one expected entry per driven cycle, sampled mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge wclk);
            if (q_exp.size() > 0) begin
                e = q_exp.pop_front();
                n_tests++;
                if (gnt !== e.g) begin
                    n_fail++;
                    $display("FAIL gnt: got %b expected %b", gnt, e.g);
                end
                n_tests++;
                if (wclken !== (|e.g)) begin
                    n_fail++;
                    $display("FAIL wclken: got %b expected %b", wclken, |e.g);
                end
                n_tests++;
                if (wdata !== e.d) begin
                    n_fail++;
                    $display("FAIL wdata: got %h expected %h", wdata, e.d);
                end
                n_tests++;
                if (gnt_id !== e.id) begin
                    n_fail++;
                    $display("FAIL gnt_id: got %0d expected %0d", gnt_id, e.id);
                end
            end else if (wclken !== 1'b0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_write: got wclken=%b expected 0", wclken);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        wrst_n   = 1'b0;
        req      = 4'b0000;
        wfull    = 1'b0;
        req_data = {8'h3C, 8'hA5, 8'h21, 8'h10};
        repeat (2) @(posedge wclk);
        #1;

        // Reset holds grants off even with all requests and FIFO not full.
        step(1'b0, 4'b1111, 1'b0, 4'b0000, 2'd0);
`ifdef FIFO_WR_ARB_BURST_EN
        // Two requesters: 4 accepts each, alternating.
        for (int i = 0; i < 4; i++) step(1'b1, 4'b0011, 1'b0, 4'b0001, 2'd0);
        step(1'b1, 4'b0011, 1'b0, 4'b0010, 2'd0);
        for (int i = 0; i < 3; i++) step(1'b1, 4'b0011, 1'b0, 4'b0010, 2'd1);
        step(1'b1, 4'b0011, 1'b0, 4'b0001, 2'd1);
        // Requester 0 drops after 2 accepts; requester 3 takes over.
        step(1'b1, 4'b1001, 1'b0, 4'b0001, 2'd0);
        step(1'b1, 4'b1000, 1'b0, 4'b1000, 2'd0);
        step(1'b1, 4'b1000, 1'b0, 4'b1000, 2'd3);
        // Full stalls the burst without consuming budget.
        step(1'b1, 4'b1000, 1'b1, 4'b0000, 2'd3);
        step(1'b1, 4'b1100, 1'b0, 4'b1000, 2'd3);
        step(1'b1, 4'b1100, 1'b0, 4'b1000, 2'd3);
        step(1'b1, 4'b1100, 1'b0, 4'b0100, 2'd3);
        // Reset mid-burst on requester 2, then restart from requester 0.
        step(1'b1, 4'b0101, 1'b0, 4'b0100, 2'd2);
        step(1'b0, 4'b0101, 1'b0, 4'b0000, 2'd2);
        step(1'b1, 4'b0101, 1'b0, 4'b0001, 2'd0);
        step(1'b1, 4'b0101, 1'b0, 4'b0001, 2'd0);
        // Idle: nothing granted, gnt_id held.
        for (int i = 0; i < 10; i++) step(1'b1, 4'b0000, 1'b0, 4'b0000, 2'd0);
        step(1'b1, 4'b0100, 1'b0, 4'b0100, 2'd0);
        step(1'b1, 4'b0100, 1'b0, 4'b0100, 2'd2);
`else
        // All requesting: strict rotation 0,1,2,3,0.
        step(1'b1, 4'b1111, 1'b0, 4'b0001, 2'd0);
        step(1'b1, 4'b1111, 1'b0, 4'b0010, 2'd0);
        step(1'b1, 4'b1111, 1'b0, 4'b0100, 2'd1);
        step(1'b1, 4'b1111, 1'b0, 4'b1000, 2'd2);
        step(1'b1, 4'b1111, 1'b0, 4'b0001, 2'd3);
        // Full for 3 cycles, then requester 2 written immediately.
        for (int i = 0; i < 3; i++) step(1'b1, 4'b0100, 1'b1, 4'b0000, 2'd0);
        step(1'b1, 4'b0100, 1'b0, 4'b0100, 2'd0);
        // Idle: nothing granted, gnt_id held.
        for (int i = 0; i < 10; i++) step(1'b1, 4'b0000, 1'b0, 4'b0000, 2'd2);
        // Withdrawn word is never written.
        step(1'b1, 4'b0010, 1'b1, 4'b0000, 2'd2);
        step(1'b1, 4'b1000, 1'b0, 4'b1000, 2'd2);
        // Priority wraps from 3 back to 0.
        step(1'b1, 4'b0110, 1'b0, 4'b0010, 2'd3);
        step(1'b1, 4'b0110, 1'b0, 4'b0100, 2'd1);
        step(1'b1, 4'b0011, 1'b0, 4'b0001, 2'd2);
        // Reset reloads the pointer so requester 0 wins first.
        step(1'b0, 4'b0101, 1'b0, 4'b0000, 2'd0);
        step(1'b1, 4'b0101, 1'b0, 4'b0001, 2'd0);
        step(1'b1, 4'b0101, 1'b0, 4'b0100, 2'd0);
`endif
        req = 4'b0000;
        @(negedge wclk);
        n_tests++;
        if (q_exp.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", q_exp.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
